alu_sched: RTL
==============

// Module: alu_sched
// PURPOSE
//  Shares one single-cycle 32-bit ALU instance between two requesters (e.g. EX stage, address unit).
//  Arbitrates requests, drives the ALU with registered operands and holds them stable.
//  Multiply gets a MUL_LAT-cycle window; every other op gets one cycle.
//  Returns one tagged result per accepted op.
// PARAMETERS
//  DATA_W   32  operand/result width
//  MUL_LAT  3   EXEC cycles for ctrl 3'b100 (mul); legal range >=1
//  CNT_W    2   latency counter width; must satisfy 2**CNT_W >= MUL_LAT
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       reset, asynchronous, active-high
//  reqN_valid_i   in   1       N=0,1: request pending
//  reqN_ready_o   out  1       N=0,1: request accepted this cycle (valid&ready)
//  reqN_data1_i   in   DATA_W  N=0,1: operand 1
//  reqN_data2_i   in   DATA_W  N=0,1: operand 2
//  reqN_ctrl_i    in   3       N=0,1: ALU op (000 and,001 or,010 add,011 sub,100 mul,111 nop)
//  alu_data1_o    out  DATA_W  to ALU data1
//  alu_data2_o    out  DATA_W  to ALU data2
//  alu_ctrl_o     out  3       to ALU control
//  alu_data_i     in   DATA_W  from ALU result
//  alu_zero_i     in   1       from ALU zero flag
//  resp_valid_o   out  1       one-cycle result strobe; no backpressure
//  resp_id_o      out  1       requester index of result
//  resp_data_o    out  DATA_W  result
//  resp_zero_o    out  1       result==0
//  resp_err_o     out  1       op code was 101/110 (illegal)
//  busy_o         out  1       FSM not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0 except alu_ctrl_o=3'b111; last_grant=1.
//  FSM IDLE/EXEC/RESP:
//   IDLE: ready to winner if any valid -> EXEC; else stay.
//   EXEC: cnt==0 -> capture alu_* into resp regs, go RESP; else cnt--.
//   RESP: resp_valid_o=1. Arbiter also live, so back-to-back ops are allowed.
//         Accept -> EXEC, else -> IDLE.
//  Accept (cycle T): latch operands/ctrl/id into alu_*_o regs; cnt = mul ? MUL_LAT-1 : 0.
//  Latency: resp_valid_o high in cycle T+1+L. L=MUL_LAT for mul, L=1 otherwise.
//  alu_*_o stable from T+1 until the next accept. IDLE after RESP drives alu_ctrl_o=111.
//  ready_o only in IDLE/RESP, at most one port per cycle, combinational from valid and state.
//  Illegal ctrl 101/110: accepted with L=1; resp_data_o=0, resp_zero_o=1, resp_err_o=1.
//  resp_data_o/resp_id_o/resp_zero_o/resp_err_o hold last value until next capture.
//  Requester must hold valid and operands until ready. Dropping valid before ready is legal; no op.
//  rst_i mid-op: immediate IDLE, in-flight op discarded, no resp_valid_o.
// CONFIGURATION
//  ALU_SCHED_RR_EN defined:
//   round-robin; on simultaneous valid, grant port != last_grant; last_grant updates on accept.
//  Undefined:
//   fixed priority, port 0 always wins; last_grant unused (port 1 can starve).
// STRUCTURE
//  Shared package alu_sched_pkg:
//   ALU op codes ALU_AND..ALU_MUL, ALU_NOP=3'b111.
//   State enum {S_IDLE,S_EXEC,S_RESP}.
//   is_mul()/is_illegal() helper functions.
//  One sub-module alu_sched_arb:
//   2-way grant logic with last_grant register; the macro switch lives only here.
//  ALU itself stays outside; connected via alu_* ports.
// TESTING
//  1 req0 add 5+7 at T -> resp_valid T+2, id=0, data=12, zero=0; busy_o high T+1..T+2.
//  2 req1 mul 6*7 -> resp_valid T+1+MUL_LAT (T+4 default), data=42; alu_*_o constant in EXEC.
//  3 Both valid continuously, and ops -> RR: grants 0,1,0,1, one per 2 cycles.
//    Without macro: all grants to 0.
//  4 req0 sub 9-9 -> data=0, zero=1; back-to-back: second accept in RESP cycle, resp 2 cycles later.
//  5 ctrl=101 -> resp_err=1, data=0, zero=1 at T+2; following legal op returns err=0.
//  6 rst_i pulse during mul EXEC -> same cycle busy_o=0, alu_ctrl_o=111; no resp_valid afterwards.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared ALU op codes, scheduler state encoding and op-classification helpers.
package alu_sched_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic is_mul(input logic [2:0] ctrl);
        return ctrl == ALU_MUL;
    endfunction

    function automatic logic is_illegal(input logic [2:0] ctrl);
        return (ctrl == 3'b101) || (ctrl == 3'b110);
    endfunction

endpackage

// File: rtl/alu_sched_arb.sv
// Two-way request arbiter. Define ALU_SCHED_RR_EN for round-robin; otherwise port 0 has
// fixed priority and the last-grant history is not kept.
module alu_sched_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic w_pick1;

`ifdef ALU_SCHED_RR_EN
    logic r_last;

    // On contention, favour the port that did not win last time.
    always_comb begin
        w_pick1 = valid1_i;
        if (valid0_i && valid1_i) begin
            w_pick1 = ~r_last;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (en_i && (valid0_i || valid1_i)) begin
            r_last <= w_pick1;
        end
    end
`else
    logic w_unused;

    assign w_pick1  = valid1_i && !valid0_i;
    assign w_unused = clk_i ^ rst_i;
`endif

    assign gnt0_o = en_i && valid0_i && !w_pick1;
    assign gnt1_o = en_i && valid1_i && w_pick1;

endmodule

// File: rtl/alu_sched.sv
// Shares one external single-cycle ALU between two requesters; mul gets a MUL_LAT-cycle window.
// Optional macro ALU_SCHED_RR_EN selects round-robin arbitration (see alu_sched_arb).
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_data1_i,
    input  logic [DATA_W-1:0] req0_data2_i,
    input  logic [2:0]        req0_ctrl_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_data1_i,
    input  logic [DATA_W-1:0] req1_data2_i,
    input  logic [2:0]        req1_ctrl_i,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [2:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_zero_i,
    output logic              resp_valid_o,
    output logic              resp_id_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_zero_o,
    output logic              resp_err_o,
    output logic              busy_o
);

    state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_id;
    logic [DATA_W-1:0] r_alu_data1, r_alu_data2, r_resp_data;
    logic [2:0]        r_alu_ctrl;
    logic              r_resp_id, r_resp_zero, r_resp_err;

    logic              w_accept_en, w_gnt0, w_gnt1, w_accept;
    logic [DATA_W-1:0] w_sel_data1, w_sel_data2;
    logic [2:0]        w_sel_ctrl;

    assign w_accept_en = (r_state == S_IDLE) || (r_state == S_RESP);

    alu_sched_arb u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (w_accept_en),
        .valid0_i (req0_valid_i),
        .valid1_i (req1_valid_i),
        .gnt0_o   (w_gnt0),
        .gnt1_o   (w_gnt1)
    );

    assign w_accept    = w_gnt0 || w_gnt1;
    assign w_sel_data1 = w_gnt1 ? req1_data1_i : req0_data1_i;
    assign w_sel_data2 = w_gnt1 ? req1_data2_i : req0_data2_i;
    assign w_sel_ctrl  = w_gnt1 ? req1_ctrl_i  : req0_ctrl_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RESP: w_state_nxt = w_accept ? S_EXEC : S_IDLE;
            S_EXEC:         if (r_cnt == '0) w_state_nxt = S_RESP;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_id        <= 1'b0;
            r_alu_data1 <= '0;
            r_alu_data2 <= '0;
            r_alu_ctrl  <= ALU_NOP;
            r_resp_id   <= 1'b0;
            r_resp_data <= '0;
            r_resp_zero <= 1'b0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_alu_data1 <= w_sel_data1;
                r_alu_data2 <= w_sel_data2;
                r_alu_ctrl  <= w_sel_ctrl;
                r_id        <= w_gnt1;
                r_cnt       <= is_mul(w_sel_ctrl) ? CNT_W'(MUL_LAT - 1) : '0;
            end else if (w_accept_en) begin
                r_alu_ctrl  <= ALU_NOP;
            end
            if (r_state == S_EXEC) begin
                if (r_cnt == '0) begin
                    r_resp_id <= r_id;
                    // Illegal ops never reach the result bus; report a zero result instead.
                    if (is_illegal(r_alu_ctrl)) begin
                        r_resp_data <= '0;
                        r_resp_zero <= 1'b1;
                        r_resp_err  <= 1'b1;
                    end else begin
                        r_resp_data <= alu_data_i;
                        r_resp_zero <= alu_zero_i;
                        r_resp_err  <= 1'b0;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;
    assign alu_data1_o  = r_alu_data1;
    assign alu_data2_o  = r_alu_data2;
    assign alu_ctrl_o   = r_alu_ctrl;
    assign resp_valid_o = (r_state == S_RESP);
    assign resp_id_o    = r_resp_id;
    assign resp_data_o  = r_resp_data;
    assign resp_zero_o  = r_resp_zero;
    assign resp_err_o   = r_resp_err;
    assign busy_o       = (r_state != S_IDLE);

endmodule
